// File: rtl/four_to_two_encoder.sv
// Registered 4-input priority encoder (d > c > b > a) with valid and
// multiple-request flags, behind IN_STAGES input register stages.
module four_to_two_encoder #(
  parameter int IN_STAGES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y1,
  output logic y0,
  output logic v,
  output logic multi
);

  function automatic logic [1:0] encode_idx(input logic [3:0] req);
    logic [1:0] idx;
    casez (req)
      4'b1???: idx = 2'b11;
      4'b01??: idx = 2'b10;
      4'b001?: idx = 2'b01;
      default: idx = 2'b00;
    endcase
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [3:0] req);
    return (req & (req - 4'd1)) != 4'd0;
  endfunction

  logic [3:0] staged_s;

  generate
    if (IN_STAGES == 0) begin : g_direct
      assign staged_s = {d, c, b, a};
    end else begin : g_pipe
      logic [3:0] stage_q [IN_STAGES];
      for (genvar g = 0; g < IN_STAGES; g++) begin : g_stage
        logic [3:0] stage_d;
        if (g == 0) begin : g_first
          assign stage_d = {d, c, b, a};
        end else begin : g_next
          assign stage_d = stage_q[g-1];
        end

        // Input delay stage g; reset flushes any in-flight request vector.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            stage_q[g] <= 4'd0;
          end else begin
            stage_q[g] <= stage_d;
          end
        end
      end
      assign staged_s = stage_q[IN_STAGES-1];
    end
  endgenerate

  logic [1:0] y_d;
  logic       v_d;
  logic       multi_d;
  logic [1:0] y_q;
  logic       v_q;
  logic       multi_q;

  // Encode the staged vector.
  always_comb begin
    y_d     = encode_idx(staged_s);
    v_d     = |staged_s;
    multi_d = multi_hot(staged_s);
  end

  // Output register: index and flags always update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= 2'b00;
      v_q     <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      v_q     <= v_d;
      multi_q <= multi_d;
    end
  end

  assign y1    = y_q[1];
  assign y0    = y_q[0];
  assign v     = v_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_four_to_two_encoder.sv
// Directed bench for four_to_two_encoder: reset, back-to-back one-hot sweep,
// all 16 patterns, latency for IN_STAGES 0..3 and mid-stream reset.
module tb_four_to_two_encoder;

  logic clk;
  logic rst_n;
  logic a, b, c, d;
  logic y1_1, y0_1, v_1, multi_1;
  logic y1_0, y0_0, v_0, multi_0;
  logic y1_2, y0_2, v_2, multi_2;
  logic y1_3, y0_3, v_3, multi_3;

  int checks_r;
  int errors_r;

  four_to_two_encoder #(.IN_STAGES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .y1(y1_1), .y0(y0_1), .v(v_1), .multi(multi_1)
  );
  four_to_two_encoder #(.IN_STAGES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .y1(y1_0), .y0(y0_0), .v(v_0), .multi(multi_0)
  );
  four_to_two_encoder #(.IN_STAGES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .y1(y1_2), .y0(y0_2), .v(v_2), .multi(multi_2)
  );
  four_to_two_encoder #(.IN_STAGES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .y1(y1_3), .y0(y0_3), .v(v_3), .multi(multi_3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed values are packed as {y1, y0, v, multi}.
  task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] out1();
    return {4'd0, y1_1, y0_1, v_1, multi_1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] abcd);
    a = abcd[3];
    b = abcd[2];
    c = abcd[1];
    d = abcd[0];
  endtask

  // Expected {y1,y0,v,multi} per pattern {a,b,c,d}, worked out by hand.
  logic [3:0] exp_tab [16];
  logic [3:0] sweep_in  [4];
  logic [3:0] sweep_exp [4];
  int lat [4];

  initial begin
    exp_tab = '{4'b0000, 4'b1110, 4'b1010, 4'b1111,
                4'b0110, 4'b1111, 4'b1011, 4'b1111,
                4'b0010, 4'b1111, 4'b1011, 4'b1111,
                4'b0111, 4'b1111, 4'b1011, 4'b1111};
    sweep_in  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    sweep_exp = '{4'b0010, 4'b0110, 4'b1010, 4'b1110};
    checks_r = 0;
    errors_r = 0;

    // Reset with all requests high
    rst_n = 1'b1;
    drive(4'b1111);
    #2 rst_n = 1'b0;
    #1 check_value("reset_immediate", out1(), 8'h00);
    tick();
    tick();
    check_value("reset_held", out1(), 8'h00);
    check_value("reset_held_s3", {4'd0, y1_3, y0_3, v_3, multi_3}, 8'h00);
    #3 rst_n = 1'b1;
    tick();
    check_value("post_reset_edge1", out1(), 8'h00);
    tick();
    check_value("post_reset_edge2", out1(), 8'h0F);

    // Back-to-back one-hot sweep
    for (int i = 0; i < 4; i++) begin
      drive(sweep_in[i]);
      tick();
      if (i > 0) check_value($sformatf("onehot_%0d", i - 1), out1(), {4'd0, sweep_exp[i-1]});
    end
    drive(4'b0000);
    tick();
    check_value("onehot_3", out1(), {4'd0, sweep_exp[3]});
    tick();
    check_value("no_request", out1(), 8'h00);

    // All 16 patterns back to back, a as MSB of the count
    for (int i = 0; i < 17; i++) begin
      if (i < 16) drive(i[3:0]);
      else drive(4'b0000);
      tick();
      if (i > 0) check_value($sformatf("prio_%0d", i - 1), out1(), {4'd0, exp_tab[i-1]});
    end

    // Latency per IN_STAGES: step d 0 -> 1
    drive(4'b0000);
    for (int i = 0; i < 5; i++) tick();
    for (int k = 0; k < 4; k++) lat[k] = -1;
    #2 drive(4'b0001);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (lat[0] < 0 && {y1_0, y0_0, v_0} == 3'b111) lat[0] = e;
      if (lat[1] < 0 && {y1_1, y0_1, v_1} == 3'b111) lat[1] = e;
      if (lat[2] < 0 && {y1_2, y0_2, v_2} == 3'b111) lat[2] = e;
      if (lat[3] < 0 && {y1_3, y0_3, v_3} == 3'b111) lat[3] = e;
    end
    check_value("latency_s0", lat[0][7:0], 8'd1);
    check_value("latency_s1", lat[1][7:0], 8'd2);
    check_value("latency_s2", lat[2][7:0], 8'd3);
    check_value("latency_s3", lat[3][7:0], 8'd4);

    // Mid-stream reset, c still driven afterwards
    drive(4'b0000);
    for (int i = 0; i < 5; i++) tick();
    drive(4'b0010);
    tick();
    tick();
    check_value("c_before_reset", out1(), 8'h0A);
    #2 rst_n = 1'b0;
    #1 check_value("midreset_immediate", out1(), 8'h00);
    #2 rst_n = 1'b1;
    tick();
    check_value("midreset_held_c_e1", out1(), 8'h00);
    tick();
    check_value("midreset_held_c_e2", out1(), 8'h0A);

    // Mid-stream reset with c dropped: nothing from before reset survives
    drive(4'b0000);
    tick();
    drive(4'b0010);
    tick();
    #2 rst_n = 1'b0;
    drive(4'b0000);
    #1 check_value("midreset2_immediate", out1(), 8'h00);
    #2 rst_n = 1'b1;
    tick();
    check_value("midreset_drop_c_e1", out1(), 8'h00);
    tick();
    check_value("midreset_drop_c_e2", out1(), 8'h00);
    check_value("midreset_drop_c_s3", {4'd0, y1_3, y0_3, v_3, multi_3}, 8'h00);
    tick();
    tick();
    check_value("midreset_drop_c_s3_late", {4'd0, y1_3, y0_3, v_3, multi_3}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
